// File: rtl/bus8_pkg.sv
// Shared constants for the 8-bit register/FIFO bus slave: register offsets,
// FIFO geometry, sticky-bit positions and the out-of-window read value.
package bus8_pkg;

  localparam logic [3:0] OFF_ID        = 4'h0;
  localparam logic [3:0] OFF_SCRATCH   = 4'h1;
  localparam logic [3:0] OFF_CTRL      = 4'h2;
  localparam logic [3:0] OFF_STATUS    = 4'h3;
  localparam logic [3:0] OFF_FIFO_DATA = 4'h4;
  localparam logic [3:0] OFF_LEVEL     = 4'h5;
  localparam logic [3:0] OFF_STICKY    = 4'h6;

  localparam logic [7:0] OOW_READ_VALUE = 8'hEE;

  localparam int FIFO_DEPTH = 8;
  localparam int FIFO_PTR_W = $clog2(FIFO_DEPTH);
  localparam int FIFO_CNT_W = FIFO_PTR_W + 1;

  localparam int STICKY_OVF = 0;
  localparam int STICKY_UDF = 1;

  function automatic logic [7:0] level_byte(input logic full, input logic empty,
                                            input logic [FIFO_CNT_W-1:0] count);
    return {full, empty, 2'b00, count};
  endfunction

endpackage

// File: rtl/bus8_sync_fifo.sv
// Single-clock FIFO with wrapping pointers and an explicit occupancy count.
// Push while full is accepted only when a pop happens in the same cycle.
module bus8_sync_fifo
  import bus8_pkg::*;
#(
  parameter int DEPTH = FIFO_DEPTH,
  parameter int WIDTH = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        push,
  input  logic                        pop,
  input  logic [WIDTH-1:0]            din,
  output logic [WIDTH-1:0]            head,
  output logic                        full,
  output logic                        empty,
  output logic [$clog2(DEPTH):0]      count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = empty ? '0 : mem[rd_ptr];

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // NOTE: storage is deliberately left out of reset; the reset pointers and
  // count make stale contents unreachable, and this keeps it a plain RAM.
  always_ff @(posedge clk) begin
    if (do_push && !rst) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/bus8_reg_fifo_slave.sv
// 16-byte register window on a single-cycle strobe bus: ID, scratch, control,
// status, a push/pop FIFO port, FIFO level and W1C sticky error flags.
module bus8_reg_fifo_slave
  import bus8_pkg::*;
#(
  parameter logic [15:0] BASE_ADDR = 16'h0000,
  parameter logic [7:0]  ID_VALUE  = 8'hA5
) (
  input  logic        i_Bus_Clk,
  input  logic        i_Bus_Rst,
  input  logic        i_Bus_CS,
  input  logic        i_Bus_Wr_Rd_n,
  input  logic [15:0] i_Bus_Addr8,
  input  logic [7:0]  i_Bus_Wr_Data,
  output logic [7:0]  o_Bus_Rd_Data,
  output logic        o_Bus_Rd_DV,
  output logic [7:0]  o_Ctrl,
  input  logic [7:0]  i_Status,
  output logic [7:0]  o_FIFO_Data,
  input  logic        i_FIFO_Pop,
  output logic        o_FIFO_Full,
  output logic        o_FIFO_Empty,
  output logic        o_Irq
);

  logic                  in_window;
  logic [3:0]            offset;
  logic                  rd_any;
  logic                  rd_hit;
  logic                  wr_hit;
  logic                  bus_push;
  logic                  bus_pop;
  logic                  fifo_push;
  logic                  fifo_pop;
  logic                  overflow;
  logic                  underflow;

  logic [7:0]            scratch;
  logic [7:0]            ctrl;
  logic [1:0]            sticky;
  logic [1:0]            sticky_next;
  logic [7:0]            rd_value;
  logic                  rd_dv;
  logic [7:0]            rd_data;

  logic [7:0]            fifo_head;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic [FIFO_CNT_W-1:0] fifo_count;

  assign in_window = (i_Bus_Addr8[15:4] == BASE_ADDR[15:4]);
  assign offset    = i_Bus_Addr8[3:0];
  assign rd_any    = i_Bus_CS && !i_Bus_Wr_Rd_n;
  assign rd_hit    = rd_any && in_window;
  assign wr_hit    = i_Bus_CS && i_Bus_Wr_Rd_n && in_window;
  assign bus_push  = wr_hit && (offset == OFF_FIFO_DATA);
  assign bus_pop   = rd_hit && (offset == OFF_FIFO_DATA);

  // The bus pop owns the read port; a simultaneous local pop is dropped.
  assign fifo_push = bus_push && !i_Bus_Rst;
  assign fifo_pop  = !i_Bus_Rst && !fifo_empty && (bus_pop || i_FIFO_Pop);
  assign overflow  = bus_push && fifo_full && !fifo_pop;
  assign underflow = bus_pop && fifo_empty;

  bus8_sync_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk   (i_Bus_Clk),
    .rst   (i_Bus_Rst),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .din   (i_Bus_Wr_Data),
    .head  (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // NOTE: every variable assigned in always_comb gets a default first so no
  // path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    rd_value = 8'h00;
    if (!in_window) begin
      rd_value = OOW_READ_VALUE;
    end else begin
      case (offset)
        OFF_ID:        rd_value = ID_VALUE;
        OFF_SCRATCH:   rd_value = scratch;
        OFF_CTRL:      rd_value = ctrl;
        OFF_STATUS:    rd_value = i_Status;
        OFF_FIFO_DATA: rd_value = fifo_head;
        OFF_LEVEL:     rd_value = level_byte(fifo_full, fifo_empty, fifo_count);
        OFF_STICKY:    rd_value = {6'b000000, sticky};
        default:       rd_value = 8'h00;
      endcase
    end
  end

  always_comb begin
    sticky_next = sticky;
    if (wr_hit && (offset == OFF_STICKY)) sticky_next = sticky & ~i_Bus_Wr_Data[1:0];
    if (overflow)  sticky_next[STICKY_OVF] = 1'b1;
    if (underflow) sticky_next[STICKY_UDF] = 1'b1;
  end

  always_ff @(posedge i_Bus_Clk) begin
    if (i_Bus_Rst) begin
      scratch <= 8'h00;
      ctrl    <= 8'h00;
      sticky  <= 2'b00;
      rd_dv   <= 1'b0;
      rd_data <= 8'h00;
    end else begin
      rd_dv  <= rd_any;
      sticky <= sticky_next;
      if (rd_any) rd_data <= rd_value;
      if (wr_hit && (offset == OFF_SCRATCH)) scratch <= i_Bus_Wr_Data;
      if (wr_hit && (offset == OFF_CTRL))    ctrl    <= i_Bus_Wr_Data;
    end
  end

  // Reset also masks a pulse already launched by the previous edge.
  assign o_Bus_Rd_DV   = rd_dv && !i_Bus_Rst;
  assign o_Bus_Rd_Data = rd_data;
  assign o_Ctrl        = ctrl;
  assign o_FIFO_Data   = fifo_head;
  assign o_FIFO_Full   = fifo_full;
  assign o_FIFO_Empty  = fifo_empty;
  assign o_Irq         = |(sticky & ctrl[1:0]);

endmodule
